// File: rtl/rv32_pkg.sv
// Shared rv32 definitions: ALU op-select encodings and the add/sub decode helper.
package rv32_pkg;

    localparam int unsigned OpselW = 5;
    localparam int unsigned XLen   = 32;

    localparam logic [OpselW-1:0] OpAdd0  = 5'd0;
    localparam logic [OpselW-1:0] OpAdd7  = 5'd7;
    localparam logic [OpselW-1:0] OpAdd15 = 5'd15;
    localparam logic [OpselW-1:0] OpAdd16 = 5'd16;
    localparam logic [OpselW-1:0] OpAdd17 = 5'd17;
    localparam logic [OpselW-1:0] OpSub1  = 5'd1;
    localparam logic [OpselW-1:0] OpSub8  = 5'd8;

    typedef enum logic [1:0] {
        AluZero,
        AluAdd,
        AluSub
    } alu_kind_e;

    function automatic alu_kind_e decode_opsel(input logic [OpselW-1:0] opsel);
        alu_kind_e kind;
        kind = AluZero;
        if (opsel == OpAdd0 || opsel == OpAdd7 || opsel == OpAdd15 ||
            opsel == OpAdd16 || opsel == OpAdd17) begin
            kind = AluAdd;
        end else if (opsel == OpSub1 || opsel == OpSub8) begin
            kind = AluSub;
        end
        return kind;
    endfunction

endpackage

// File: rtl/rv32_alu_add_sub.sv
// Combinational add/sub unit; unrecognised op-selects produce zero.
module rv32_alu_add_sub
    import rv32_pkg::*;
(
    input  logic [OpselW-1:0] opsel_i,
    input  logic [XLen-1:0]   op_a_i,
    input  logic [XLen-1:0]   op_b_i,
    output logic [XLen-1:0]   result_o
);

    alu_kind_e kind;

    always_comb begin
        kind     = decode_opsel(opsel_i);
        result_o = '0;
        unique case (kind)
            AluAdd:  result_o = op_a_i + op_b_i;
            AluSub:  result_o = op_a_i - op_b_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/rv32_addsub_arb.sv
// Two-requester arbiter in front of a shared add/sub unit with a single-entry
// registered result stage.
module rv32_addsub_arb
    import rv32_pkg::*;
#(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_valid,
    input  logic              r1_valid,
    output logic              r0_ready,
    output logic              r1_ready,
    input  logic [OpselW-1:0] r0_opsel,
    input  logic [OpselW-1:0] r1_opsel,
    input  logic [XLen-1:0]   r0_opA,
    input  logic [XLen-1:0]   r0_opB,
    input  logic [XLen-1:0]   r1_opA,
    input  logic [XLen-1:0]   r1_opB,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [XLen-1:0]   res_data,
    output logic              res_id
);

    logic            res_valid_q, res_valid_d;
    logic [XLen-1:0] res_data_q, res_data_d;
    logic            res_id_q, res_id_d;
    logic            last_grant_q, last_grant_d;

    logic              can_accept;
    logic              grant;
    logic              gnt_id;
    logic [OpselW-1:0] alu_opsel;
    logic [XLen-1:0]   alu_a;
    logic [XLen-1:0]   alu_b;
    logic [XLen-1:0]   alu_result;

    assign can_accept = !res_valid_q || res_ready;

    // Readies never look at each other, only at valids, output stage and pointer.
    always_comb begin
        r0_ready = 1'b0;
        r1_ready = 1'b0;
        if (!rst && can_accept) begin
            if (r0_valid && r1_valid) begin
                if (FIXED_PRIO != 0) begin
                    r0_ready = 1'b1;
                end else if (last_grant_q) begin
                    r0_ready = 1'b1;
                end else begin
                    r1_ready = 1'b1;
                end
            end else if (r0_valid) begin
                r0_ready = 1'b1;
            end else if (r1_valid) begin
                r1_ready = 1'b1;
            end
        end
    end

    assign grant  = r0_ready || r1_ready;
    assign gnt_id = r1_ready;

    always_comb begin
        alu_opsel = r0_opsel;
        alu_a     = r0_opA;
        alu_b     = r0_opB;
        if (gnt_id) begin
            alu_opsel = r1_opsel;
            alu_a     = r1_opA;
            alu_b     = r1_opB;
        end
    end

    rv32_alu_add_sub u_alu (
        .opsel_i  (alu_opsel),
        .op_a_i   (alu_a),
        .op_b_i   (alu_b),
        .result_o (alu_result)
    );

    // A grant in the same cycle as a consume overwrites the entry and keeps it valid.
    always_comb begin
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_id_d     = res_id_q;
        last_grant_d = last_grant_q;
        if (grant) begin
            res_valid_d  = 1'b1;
            res_data_d   = alu_result;
            res_id_d     = gnt_id;
            last_grant_d = gnt_id;
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    // last_grant resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_id_q     <= res_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;

endmodule

// File: tb/tb_rv32_addsub_arb.sv
// Directed bench: round-robin instance plus a fixed-priority instance on shared inputs.
module tb_rv32_addsub_arb;

    logic        clk;
    logic        rst;
    logic        r0_valid, r1_valid;
    logic [4:0]  r0_opsel, r1_opsel;
    logic [31:0] r0_opA, r0_opB, r1_opA, r1_opB;
    logic        res_ready;

    logic        rr_r0_ready, rr_r1_ready, rr_res_valid, rr_res_id;
    logic [31:0] rr_res_data;
    logic        fp_r0_ready, fp_r1_ready, fp_res_valid, fp_res_id;
    logic [31:0] fp_res_data;

    int checks = 0;
    int errors = 0;

    rv32_addsub_arb #(.FIXED_PRIO(0)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .r0_valid  (r0_valid),
        .r1_valid  (r1_valid),
        .r0_ready  (rr_r0_ready),
        .r1_ready  (rr_r1_ready),
        .r0_opsel  (r0_opsel),
        .r1_opsel  (r1_opsel),
        .r0_opA    (r0_opA),
        .r0_opB    (r0_opB),
        .r1_opA    (r1_opA),
        .r1_opB    (r1_opB),
        .res_valid (rr_res_valid),
        .res_ready (res_ready),
        .res_data  (rr_res_data),
        .res_id    (rr_res_id)
    );

    rv32_addsub_arb #(.FIXED_PRIO(1)) u_fp (
        .clk       (clk),
        .rst       (rst),
        .r0_valid  (r0_valid),
        .r1_valid  (r1_valid),
        .r0_ready  (fp_r0_ready),
        .r1_ready  (fp_r1_ready),
        .r0_opsel  (r0_opsel),
        .r1_opsel  (r1_opsel),
        .r0_opA    (r0_opA),
        .r0_opB    (r0_opB),
        .r1_opA    (r1_opA),
        .r1_opB    (r1_opB),
        .res_valid (fp_res_valid),
        .res_ready (res_ready),
        .res_data  (fp_res_data),
        .res_id    (fp_res_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        r0_valid  = 1'b1;
        r1_valid  = 1'b1;
        r0_opsel  = 5'd0;
        r1_opsel  = 5'd0;
        r0_opA    = 32'h0;
        r0_opB    = 32'h0;
        r1_opA    = 32'h0;
        r1_opB    = 32'h0;
        res_ready = 1'b1;

        // Reset state; readies held low while rst is high even with valids up.
        step();
        step();
        chk("rst_res_valid", {31'b0, rr_res_valid}, 32'h0);
        chk("rst_res_data", rr_res_data, 32'h0);
        chk("rst_res_id", {31'b0, rr_res_id}, 32'h0);
        chk("rst_r0_ready", {31'b0, rr_r0_ready}, 32'h0);
        chk("rst_r1_ready", {31'b0, rr_r1_ready}, 32'h0);

        // Single requester r0: 5 + 3.
        r1_valid = 1'b0;
        r0_opsel = 5'd0;
        r0_opA   = 32'h5;
        r0_opB   = 32'h3;
        rst      = 1'b0;
        settle();
        chk("single_r0_ready", {31'b0, rr_r0_ready}, 32'h1);
        chk("single_r1_ready", {31'b0, rr_r1_ready}, 32'h0);
        step();
        r0_valid = 1'b0;
        r0_opA   = 32'hDEAD_BEEF;  // operands need not be held after grant
        chk("single_res_valid", {31'b0, rr_res_valid}, 32'h1);
        chk("single_res_data", rr_res_data, 32'h8);
        chk("single_res_id", {31'b0, rr_res_id}, 32'h0);
        step();
        chk("drain_res_valid", {31'b0, rr_res_valid}, 32'h0);

        // Fresh reset, then contention every cycle: round-robin alternates.
        rst = 1'b1;
        step();
        rst      = 1'b0;
        r0_valid = 1'b1;
        r1_valid = 1'b1;
        r0_opsel = 5'd0;
        r0_opA   = 32'h1;
        r0_opB   = 32'h2;
        r1_opsel = 5'd1;
        r1_opA   = 32'h0;
        r1_opB   = 32'h1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("rr_r0_ready", {31'b0, rr_r0_ready}, (i % 2 == 0) ? 32'h1 : 32'h0);
            chk("rr_r1_ready", {31'b0, rr_r1_ready}, (i % 2 == 1) ? 32'h1 : 32'h0);
            chk("fp_r0_ready", {31'b0, fp_r0_ready}, 32'h1);
            chk("fp_r1_ready", {31'b0, fp_r1_ready}, 32'h0);
            step();
            chk("rr_res_id", {31'b0, rr_res_id}, (i % 2 == 1) ? 32'h1 : 32'h0);
            chk("rr_res_data", rr_res_data, (i % 2 == 1) ? 32'hFFFF_FFFF : 32'h3);
            chk("fp_res_data", fp_res_data, 32'h3);
        end

        // Stall: result from r1 held, no grants, data stable.
        res_ready = 1'b0;
        settle();
        chk("stall_r0_ready", {31'b0, rr_r0_ready}, 32'h0);
        chk("stall_r1_ready", {31'b0, rr_r1_ready}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_res_valid", {31'b0, rr_res_valid}, 32'h1);
            chk("stall_res_data", rr_res_data, 32'hFFFF_FFFF);
            chk("stall_res_id", {31'b0, rr_res_id}, 32'h1);
            chk("stall_rr_r0_ready", {31'b0, rr_r0_ready}, 32'h0);
        end
        // Consume and grant in the same cycle; pointer unchanged by the stall.
        res_ready = 1'b1;
        settle();
        chk("resume_r0_ready", {31'b0, rr_r0_ready}, 32'h1);
        chk("resume_r1_ready", {31'b0, rr_r1_ready}, 32'h0);
        step();
        chk("resume_res_valid", {31'b0, rr_res_valid}, 32'h1);
        chk("resume_res_id", {31'b0, rr_res_id}, 32'h0);
        chk("resume_res_data", rr_res_data, 32'h3);

        // Arithmetic corners through r0 alone.
        r1_valid = 1'b0;
        r0_opsel = 5'd16;
        r0_opA   = 32'hFFFF_FFFF;
        r0_opB   = 32'h1;
        step();
        chk("add16_wrap", rr_res_data, 32'h0);
        r0_opsel = 5'd8;
        r0_opA   = 32'hA;
        r0_opB   = 32'h3;
        step();
        chk("sub8", rr_res_data, 32'h7);
        r0_opsel = 5'd5;
        r0_opA   = 32'h3;
        r0_opB   = 32'h4;
        step();
        chk("op5_zero", rr_res_data, 32'h0);
        r0_opsel = 5'd17;
        r0_opA   = 32'h7;
        r0_opB   = 32'h9;
        step();
        chk("add17", rr_res_data, 32'h10);
        r0_opsel = 5'd15;
        r0_opA   = 32'h1;
        r0_opB   = 32'h1;
        step();
        chk("add15", rr_res_data, 32'h2);
        r0_opsel = 5'd7;
        r0_opA   = 32'h2;
        r0_opB   = 32'h2;
        step();
        chk("add7", rr_res_data, 32'h4);

        // Single requester r1.
        r0_valid = 1'b0;
        r1_valid = 1'b1;
        r1_opsel = 5'd1;
        r1_opA   = 32'h5;
        r1_opB   = 32'h7;
        settle();
        chk("r1only_ready", {31'b0, rr_r1_ready}, 32'h1);
        step();
        chk("r1only_data", rr_res_data, 32'hFFFF_FFFE);
        chk("r1only_id", {31'b0, rr_res_id}, 32'h1);
        chk("r1only_valid", {31'b0, rr_res_valid}, 32'h1);

        // Asynchronous reset mid-cycle while a result is held.
        r1_valid  = 1'b0;
        res_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_res_valid", {31'b0, rr_res_valid}, 32'h0);
        chk("arst_res_data", rr_res_data, 32'h0);
        step();
        rst       = 1'b0;
        res_ready = 1'b1;
        step();
        chk("post_rst_no_result", {31'b0, rr_res_valid}, 32'h0);
        r0_valid = 1'b1;
        r1_valid = 1'b1;
        settle();
        chk("post_rst_r0_ready", {31'b0, rr_r0_ready}, 32'h1);
        chk("post_rst_r1_ready", {31'b0, rr_r1_ready}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
